// File: rtl/ip_stream_gen.sv
// ip_stream_gen: sends a block of NUM_WORDS words, MSB word first, over a req/ack
// handshake. Each word goes out as {tag, word}. The tag is the word index, wrapping
// modulo 2^TAG_W, or a fixed tag that is latched at start. With AUTO_START set, INIT_BLOCK
// is sent once after every reset release.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-low
//   start     in   one-cycle request to send block_in; honoured only when idle
//   block_in  in   block to send, sampled on an accepted start
//   tag_mode  in   0 = rotating tag, 1 = fixed tag (tag_in); sampled on an accepted start
//   tag_in    in   fixed tag value; sampled on an accepted start
//   data_out  out  {tag, word}, registered; holds its value while idle
//   req       out  data_out valid, registered
//   ack       in   consumer ready; a transfer happens when req and ack are both high
//   busy      out  high while sending and during the done cycle
//   done      out  one-cycle pulse after the last word is transferred
module ip_stream_gen #(
  parameter int unsigned                   DATA_W     = 8,
  parameter int unsigned                   TAG_W      = 2,
  parameter int unsigned                   NUM_WORDS  = 16,
  parameter bit                            AUTO_START = 1'b1,
  parameter logic [NUM_WORDS*DATA_W-1:0]   INIT_BLOCK = 128'h089975E92555F334CE76E4F24D932AB3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_WORDS*DATA_W-1:0]   block_in,
  input  logic                          tag_mode,
  input  logic [TAG_W-1:0]              tag_in,
  output logic [TAG_W+DATA_W-1:0]       data_out,
  output logic                          req,
  input  logic                          ack,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned BLK_W = NUM_WORDS * DATA_W;
  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned OUT_W = TAG_W + DATA_W;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_WORDS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] block_q, block_d;
  logic             mode_q, mode_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  // Armed during reset; fires the internal start on the first cycle out of reset.
  logic             auto_q, auto_d;

  // Word i of a block, counted from the most significant end.
  function automatic logic [DATA_W-1:0] word_at(input logic [BLK_W-1:0] blk,
                                                input logic [IDX_W-1:0] i);
    logic [BLK_W-1:0] shifted;
    shifted = blk >> (DATA_W * (NUM_WORDS - 1 - 32'(i)));
    return shifted[DATA_W-1:0];
  endfunction

  // Rotating tag is the low TAG_W bits of the index (zero-extended if TAG_W > IDX_W).
  function automatic logic [TAG_W-1:0] tag_for(input logic             mode,
                                               input logic [TAG_W-1:0] fixed_tag,
                                               input logic [IDX_W-1:0] i);
    logic [TAG_W-1:0] rot;
    rot = TAG_W'(i);
    return mode ? fixed_tag : rot;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    block_d = block_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    data_d  = data_q;
    auto_d  = auto_q;

    case (state_q)
      StIdle: begin
        if (auto_q) begin
          auto_d  = 1'b0;
          block_d = INIT_BLOCK;
          mode_d  = 1'b0;
          idx_d   = '0;
          data_d  = {tag_for(1'b0, tag_q, '0), word_at(INIT_BLOCK, '0)};
          state_d = StSend;
        end else if (start) begin
          block_d = block_in;
          mode_d  = tag_mode;
          tag_d   = tag_in;
          idx_d   = '0;
          data_d  = {tag_for(tag_mode, tag_in, '0), word_at(block_in, '0)};
          state_d = StSend;
        end
      end
      StSend: begin
        // req is always high here, so ack alone marks a transfer.
        if (ack) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = {tag_for(mode_q, tag_q, idx_d), word_at(block_q, idx_d)};
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    req_d  = (state_d == StSend);
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      block_q <= INIT_BLOCK;
      mode_q  <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      block_q <= block_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      auto_q  <= auto_d;
    end
  end

  assign data_out = data_q;
  assign req      = req_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/ip_stream_gen.md
IP_STREAM_GEN -- requirements
Module: ip_stream_gen

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per word.
REQ-002 Parameter TAG_W, default 2, tag bits prefixed to each word.
REQ-003 Parameter NUM_WORDS, default 16, words per block; legal range is 2 to 256.
REQ-004 Parameter AUTO_START, default 1, if 1 send INIT_BLOCK once after reset release.
REQ-005 Parameter INIT_BLOCK, default 128'h089975E92555F334CE76E4F24D932AB3, width NUM_WORDS*DATA_W, block used by auto-start.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-low (0 = reset).
REQ-008 start  input  1  one-cycle request to send block_in; accepted only in IDLE.
REQ-009 block_in  input  NUM_WORDS*DATA_W  block to send; sampled on accepted start.
REQ-010 tag_mode  input  1  0 = rotating tag, 1 = fixed tag; sampled on accepted start.
REQ-011 tag_in  input  TAG_W  fixed tag value; sampled on accepted start.
REQ-012 data_out  output  TAG_W+DATA_W  {tag, word}, registered.
REQ-013 req  output  1  data_out valid, registered.
REQ-014 ack  input  1  consumer ready; a transfer occurs on any cycle with req=1 and ack=1.
REQ-015 busy  output  1  high in SEND and DONE states.
REQ-016 done  output  1  one-cycle pulse after the last word is transferred.

Function
REQ-017 FSM states: IDLE, SEND, DONE.
REQ-018 IDLE with start=1: latch block_in, tag_mode and tag_in, clear idx to 0, go to SEND; req=1 and data_out=word 0 on the next cycle (latency 1).
REQ-019 Word order is MSB first: word idx = block[NUM_WORDS*DATA_W-1-DATA_W*idx -: DATA_W].
REQ-020 Tag with tag_mode=0 is idx[TAG_W-1:0], wrapping modulo 2^TAG_W; with tag_mode=1 it is the latched tag_in for every word.
REQ-021 In SEND, req and data_out hold stable until transfer; ack=0 stalls indefinitely with no change.
REQ-022 Transfer with idx<NUM_WORDS-1: idx+1; data_out updates to the next word on the next cycle; req stays 1, so back-to-back transfers give one word per cycle.
REQ-023 Transfer with idx=NUM_WORDS-1: go to DONE; req=0 on the next cycle.
REQ-024 DONE lasts one cycle: done=1, req=0, busy=1; then go to IDLE.
REQ-025 start in SEND or DONE is ignored with no effect; ack while req=0 is ignored.
REQ-026 idx width is $clog2(NUM_WORDS); it never exceeds NUM_WORDS-1.
REQ-027 In IDLE: req=0, busy=0, done=0; data_out holds its last value.

Reset
REQ-028 While reset=0: state=IDLE, idx=0, req=0, busy=0, done=0, data_out=0, latched block=INIT_BLOCK, tag_mode latch=0.
REQ-029 Reset asserted mid-block aborts the transfer at once; no done pulse is issued.
REQ-030 AUTO_START=1: the first cycle with reset=1 acts as an internal start using INIT_BLOCK with tag_mode=0; req=1 on the following cycle; it fires once per reset release.
REQ-031 AUTO_START=0: stay in IDLE after reset until start=1.

Verification
REQ-032 Defaults, ack tied 1, reset released -> 16 consecutive req cycles with data_out 0x008, 0x199, 0x275, 0x3E9, 0x025 ... 0x3B3; done pulses one cycle after the last word; then idle.
REQ-033 Defaults with ack low for 5 cycles during word 3 -> data_out held at 0x3E9 with req=1 for all 5 cycles; no word lost or duplicated.
REQ-034 AUTO_START=0, start with tag_mode=1, tag_in=2'b10 -> all 16 words carry tag 2'b10.
REQ-035 start pulsed during SEND and again during DONE -> ignored; exactly 16 transfers and one done pulse.
REQ-036 reset=0 after 7 transfers -> req=0 and data_out=0 the next cycle; no done pulse; auto-start resends from word 0 after release.
REQ-037 TAG_W=3, NUM_WORDS=20, DATA_W=8 -> tags run 0..7,0..7,0..3; exactly 20 transfers, then done.
